// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver, 1 start bit, 1 stop bit, LSB first.
// Optional even-parity bit after data bit 7, enabled by defining UART_RX_PARITY_EN.
// CLKS_PER_BIT must be even and >= 4; sampling happens mid-bit.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] CntZero = '0;
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StStop     = 3'd3,
    StWaitHigh = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    StParity   = 3'd5
`endif
  } state_e;

  state_e state_q, state_d;

  logic            rx_meta_q;
  logic            rxs;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;
  logic            perr_q, perr_d;
  logic            bit_hit;
  logic            start_hit;
  logic            par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_q, par_d;
  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign par_bad = ^{shift_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  assign bit_hit   = (cnt_q == CntLast);
  assign start_hit = (cnt_q == CntHalf);

  // Two-flop synchronizer; flops reset high so a line held low is seen only once filled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_q <= 1'b1;
      rxs       <= 1'b1;
    end else begin
      rx_meta_q <= rx_pin;
      rxs       <= rx_meta_q;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (!rxs) state_d = StStart;
      end
      StStart: begin
        // A start bit that is high again by mid-bit is a glitch.
        if (start_hit) state_d = rxs ? StIdle : StData;
      end
      StData: begin
        if (bit_hit && (bit_idx_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
          state_d = StParity;
`else
          state_d = StStop;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (bit_hit) state_d = StStop;
      end
`endif
      StStop: begin
        if (bit_hit) state_d = rxs ? StIdle : StWaitHigh;
      end
      StWaitHigh: begin
        // Hold here through a break so it produces a single frame_err.
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: bit timing, shift register and registered output pulses.
  always_comb begin
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d     = CntZero;
        bit_idx_d = 3'd0;
      end
      StStart: begin
        cnt_d = start_hit ? CntZero : (cnt_q + CntOne);
      end
      StData: begin
        if (bit_hit) begin
          cnt_d     = CntZero;
          shift_d   = {rxs, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (bit_hit) begin
          cnt_d = CntZero;
          par_d = rxs;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
`endif
      StStop: begin
        if (bit_hit) begin
          cnt_d = CntZero;
          // Frame error wins over parity error; either one leaves rx_data alone.
          if (!rxs) begin
            ferr_d = 1'b1;
          end else if (par_bad) begin
            perr_d = 1'b1;
          end else begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StWaitHigh: begin
        cnt_d = CntZero;
      end
      default: begin
        cnt_d     = CntZero;
        bit_idx_d = 3'd0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= CntZero;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      data_q    <= 8'h00;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Captured parity bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  // Output logic.
  always_comb begin
    rx_busy    = (state_q != StIdle);
    rx_data    = data_q;
    rx_valid   = valid_q;
    frame_err  = ferr_q;
    parity_err = perr_q;
  end

  pulse_excl_a: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({rx_valid, frame_err, parity_err}));

  valid_one_cycle_a: assert property (@(posedge clk) disable iff (!reset)
    rx_valid |=> !rx_valid);

  ferr_one_cycle_a: assert property (@(posedge clk) disable iff (!reset)
    frame_err |=> !frame_err);

  idle_not_busy_a: assert property (@(posedge clk) disable iff (!reset)
    (state_q == StIdle) |-> !rx_busy);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at CLKS_PER_BIT = 16.
module tb_uart_rx;

  localparam int unsigned Cpb = 16;
`ifdef UART_RX_PARITY_EN
  localparam int FrameBits = 11;
`else
  localparam int FrameBits = 10;
`endif
  localparam int FrameCycles = FrameBits * Cpb;

  logic       clk;
  logic       reset;
  logic       rx_pin;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;

  uart_rx #(.CLKS_PER_BIT(Cpb)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_pin     (rx_pin),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Pulse monitor, sampled on the falling edge.
  int         cyc = 0;
  int         valid_cnt = 0;
  int         ferr_cnt = 0;
  int         perr_cnt = 0;
  logic [7:0] vdata[$];
  int         vcyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt <= valid_cnt + 1;
      vdata.push_back(rx_data);
      vcyc.push_back(cyc);
    end
    if (frame_err) ferr_cnt <= ferr_cnt + 1;
    if (parity_err) perr_cnt <= perr_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Drive nbits LSB first, one bit per Cpb cycles; busy must be high mid data bit.
  task automatic send_bits(input logic [10:0] bits, input int nbits, output logic busy_ok);
    busy_ok = 1'b1;
    for (int i = 0; i < nbits; i++) begin
      rx_pin = bits[i];
      repeat (Cpb / 2) @(negedge clk);
      if (i >= 1 && i <= 8 && !rx_busy) busy_ok = 1'b0;
      repeat (Cpb / 2) @(negedge clk);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic stop_b,
                                           input logic par_flip);
    logic [10:0] f;
`ifdef UART_RX_PARITY_EN
    f = {stop_b, (^d) ^ par_flip, d, 1'b0};
`else
    f = {1'b0, stop_b, d, 1'b0};
    f[10] = par_flip & 1'b0;
`endif
    return f;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       stop_bit;
    logic       par_flip;
    int         extra_low;
    int         exp_valid;
    int         exp_ferr;
    int         exp_perr;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic        busy_ok;
    logic [10:0] fr;
    int          bv, bf, bp, nq;

    vecs.push_back('{8'hA5, 1'b1, 1'b0, 0,  1, 0, 0, 8'hA5});
    vecs.push_back('{8'h3C, 1'b0, 1'b0, 40, 0, 1, 0, 8'hA5});
    vecs.push_back('{8'h55, 1'b1, 1'b0, 0,  1, 0, 0, 8'h55});
    vecs.push_back('{8'h00, 1'b1, 1'b0, 0,  1, 0, 0, 8'h00});
    vecs.push_back('{8'hFF, 1'b1, 1'b0, 0,  1, 0, 0, 8'hFF});
    vecs.push_back('{8'h81, 1'b1, 1'b0, 0,  1, 0, 0, 8'h81});
`ifdef UART_RX_PARITY_EN
    vecs.push_back('{8'h07, 1'b1, 1'b0, 0,  1, 0, 0, 8'h07});
    vecs.push_back('{8'h07, 1'b1, 1'b1, 0,  0, 0, 1, 8'h07});
    vecs.push_back('{8'hE1, 1'b0, 1'b1, 20, 0, 1, 0, 8'h07});
`endif

    rx_pin = 1'b1;
    reset  = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_rx_data", {24'h0, rx_data}, 32'h00);
    chk("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("reset_rx_busy", {31'h0, rx_busy}, 32'h0);
    chk("reset_frame_err", {31'h0, frame_err}, 32'h0);
    chk("reset_parity_err", {31'h0, parity_err}, 32'h0);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // Table-driven frames.
    for (int k = 0; k < vecs.size(); k++) begin
      bv = valid_cnt; bf = ferr_cnt; bp = perr_cnt;
      fr = mk_frame(vecs[k].data, vecs[k].stop_bit, vecs[k].par_flip);
      send_bits(fr, FrameBits, busy_ok);
      if (vecs[k].extra_low > 0) begin
        rx_pin = 1'b0;
        repeat (vecs[k].extra_low) @(negedge clk);
      end
      rx_pin = 1'b1;
      repeat (40) @(negedge clk);
      chk($sformatf("vec%0d_busy", k), {31'h0, busy_ok}, 32'h1);
      chk($sformatf("vec%0d_valid_cnt", k), valid_cnt - bv, vecs[k].exp_valid);
      chk($sformatf("vec%0d_ferr_cnt", k), ferr_cnt - bf, vecs[k].exp_ferr);
      chk($sformatf("vec%0d_perr_cnt", k), perr_cnt - bp, vecs[k].exp_perr);
      chk($sformatf("vec%0d_rx_data", k), {24'h0, rx_data}, {24'h0, vecs[k].exp_data});
    end

    // Back-to-back frames with no idle gap.
    bv = valid_cnt; nq = vdata.size();
    send_bits(mk_frame(8'h00, 1'b1, 1'b0), FrameBits, busy_ok);
    send_bits(mk_frame(8'hFF, 1'b1, 1'b0), FrameBits, busy_ok);
    rx_pin = 1'b1;
    repeat (40) @(negedge clk);
    chk("b2b_valid_cnt", valid_cnt - bv, 2);
    if (vdata.size() >= nq + 2) begin
      chk("b2b_first", {24'h0, vdata[nq]}, 32'h00);
      chk("b2b_second", {24'h0, vdata[nq+1]}, 32'hFF);
      chk("b2b_spacing", vcyc[nq+1] - vcyc[nq], FrameCycles);
    end

    // Short low glitch on an idle line.
    bv = valid_cnt; bf = ferr_cnt;
    rx_pin = 1'b0;
    repeat (4) @(negedge clk);
    chk("glitch_busy_during", {31'h0, rx_busy}, 32'h1);
    rx_pin = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_valid_cnt", valid_cnt - bv, 0);
    chk("glitch_ferr_cnt", ferr_cnt - bf, 0);
    chk("glitch_busy_after", {31'h0, rx_busy}, 32'h0);

    // Reset in the middle of data bit 4.
    fr = mk_frame(8'h96, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rx_pin = fr[i];
      repeat (Cpb) @(negedge clk);
    end
    rx_pin = fr[5];
    repeat (Cpb / 2) @(negedge clk);
    bv = valid_cnt; bf = ferr_cnt; bp = perr_cnt;
    reset = 1'b0;
    #1;
    chk("midrst_busy", {31'h0, rx_busy}, 32'h0);
    chk("midrst_rx_data", {24'h0, rx_data}, 32'h00);
    chk("midrst_rx_valid", {31'h0, rx_valid}, 32'h0);
    chk("midrst_frame_err", {31'h0, frame_err}, 32'h0);
    rx_pin = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (Cpb * 12) @(negedge clk);
    chk("midrst_no_pulse", (valid_cnt - bv) + (ferr_cnt - bf) + (perr_cnt - bp), 0);
    bv = valid_cnt;
    send_bits(mk_frame(8'h5A, 1'b1, 1'b0), FrameBits, busy_ok);
    rx_pin = 1'b1;
    repeat (40) @(negedge clk);
    chk("postrst_valid_cnt", valid_cnt - bv, 1);
    chk("postrst_rx_data", {24'h0, rx_data}, 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
